// File: rtl/button_pkg.sv
// Shared types and default constants for the button conditioner.
// The optional auto-repeat feature is selected by the BUTTON_REPEAT_EN macro
// in button_conditioner.sv; this package is identical in both builds.
package button_pkg;

    // Debounce FSM states: two stable states and two qualifying states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

    // Largest of three values; sizes the shared counter width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both flops clear on the asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, emit a one-cycle press
// pulse and a debounced level.
// Optional feature: define BUTTON_REPEAT_EN to add auto-repeat pulses while
// the button stays in PRESSED. Without it no repeat logic exists and
// REPEAT_DELAY / REPEAT_PERIOD only contribute to the counter width.
//
// Timing: btn_raw first sampled high at edge 0 and held gives the press
// pulse (and level rise) on edge DEBOUNCE_CYCLES+2.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic button,
    output logic level
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_MAX = '1;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] C_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic             w_synced;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_button;
    logic             r_level;

`ifdef BUTTON_REPEAT_EN
    logic [CNT_W-1:0] r_rep_count;
    logic             r_rep_armed;   // 0: waiting out REPEAT_DELAY, 1: pacing REPEAT_PERIOD
`endif

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_MAX) ? v : v + CNT_W'(1);
    endfunction

    // btn_raw is sampled nowhere else.
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (w_synced)
    );

    // Debounce FSM with registered pulse and level outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_button <= 1'b0;
            r_level  <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            r_rep_count <= '0;
            r_rep_armed <= 1'b0;
`endif
        end else begin
            r_button <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            // Any cycle not spent holding in PRESSED restarts the repeat delay.
            r_rep_count <= '0;
            r_rep_armed <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_synced) begin
                        r_state <= PRESS_WAIT;
                        r_count <= C_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_synced) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (r_count == C_DEB) begin
                        r_state  <= PRESSED;
                        r_count  <= '0;
                        r_button <= 1'b1;
                        r_level  <= 1'b1;
                    end else begin
                        r_count <= sat_inc(r_count);
                    end
                end
                PRESSED: begin
                    if (!w_synced) begin
                        r_state <= RELEASE_WAIT;
                        r_count <= C_ONE;
                    end else begin
`ifdef BUTTON_REPEAT_EN
                        if (!r_rep_armed) begin
                            if (r_rep_count == C_DLY_LAST) begin
                                r_button    <= 1'b1;
                                r_rep_count <= '0;
                                r_rep_armed <= 1'b1;
                            end else begin
                                r_rep_count <= sat_inc(r_rep_count);
                            end
                        end else begin
                            r_rep_armed <= 1'b1;
                            if (r_rep_count == C_PER_LAST) begin
                                r_button    <= 1'b1;
                                r_rep_count <= '0;
                            end else begin
                                r_rep_count <= sat_inc(r_rep_count);
                            end
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (w_synced) begin
                        // Bounce back: keep the press, no new pulse.
                        r_state <= PRESSED;
                        r_count <= '0;
                    end else if (r_count == C_DEB) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_count <= sat_inc(r_count);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign button = r_button;
    assign level  = r_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. "Edge 0" is the first rising edge that samples a new btn_raw.
module tb_button_conditioner;

    logic clk;
    logic rst;
    logic btn_raw;
    logic button;
    logic level;

    int checks;
    int errors;

    // Downstream colour sequencer: 0 = cleared, then 1..6 wrapping to 1.
    logic [2:0] colour;
    logic       seq_clr;

    button_conditioner dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .button  (button),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Colour sequencer advanced by each press pulse.
    always @(posedge clk) begin
        if (seq_clr) colour <= 3'd0;
        else if (button) colour <= (colour == 3'd6) ? 3'd1 : colour + 3'd1;
    end

    task automatic settle_idle();
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (button !== 1'b0) begin
                errors++;
                $display("FAIL reset_button cycle %0d: got %b want 0", i, button);
            end
            checks++;
            if (level !== 1'b0) begin
                errors++;
                $display("FAIL reset_level cycle %0d: got %b want 0", i, level);
            end
        end
        @(negedge clk);
        btn_raw = 1'b0;
        rst     = 1'b1;
        settle_idle();
    endtask

    task automatic test_press();
        logic exp_b, exp_l;
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
            exp_b = (e == 6);
            exp_l = (e >= 6);
            checks++;
            if (button !== exp_b) begin
                errors++;
                $display("FAIL press_pulse edge %0d: got %b want %b", e, button, exp_b);
            end
            checks++;
            if (level !== exp_l) begin
                errors++;
                $display("FAIL press_level edge %0d: got %b want %b", e, level, exp_l);
            end
            @(negedge clk);
            btn_raw = (e + 1 <= 19);
        end
        settle_idle();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            @(posedge clk); #1;
            checks++;
            if (button !== 1'b0) begin
                errors++;
                $display("FAIL glitch_pulse edge %0d: got %b want 0", e, button);
            end
            checks++;
            if (level !== 1'b0) begin
                errors++;
                $display("FAIL glitch_level edge %0d: got %b want 0", e, level);
            end
            @(negedge clk);
            btn_raw = (e + 1 <= 2);
        end
        settle_idle();
    endtask

    // Shortest accepted press: five raw samples high.
    task automatic test_min_press();
        logic exp_b, exp_l;
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            @(posedge clk); #1;
            exp_b = (e == 6);
            exp_l = (e >= 6) && (e <= 10);
            checks++;
            if (button !== exp_b) begin
                errors++;
                $display("FAIL min_pulse edge %0d: got %b want %b", e, button, exp_b);
            end
            checks++;
            if (level !== exp_l) begin
                errors++;
                $display("FAIL min_level edge %0d: got %b want %b", e, level, exp_l);
            end
            @(negedge clk);
            btn_raw = (e + 1 <= 4);
        end
        settle_idle();
    endtask

    task automatic test_bounce_release();
        logic exp_b, exp_l;
        int   n;
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 28; e++) begin
            @(posedge clk); #1;
            exp_b = (e == 6);
            exp_l = (e >= 6) && (e <= 19);
            checks++;
            if (button !== exp_b) begin
                errors++;
                $display("FAIL bounce_pulse edge %0d: got %b want %b", e, button, exp_b);
            end
            checks++;
            if (level !== exp_l) begin
                errors++;
                $display("FAIL bounce_level edge %0d: got %b want %b", e, level, exp_l);
            end
            @(negedge clk);
            n = e + 1;
            btn_raw = (n <= 9) || (n == 12) || (n == 13);
        end
        settle_idle();
    endtask

    task automatic test_reset_mid_press();
        logic exp_b, exp_l;
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
            exp_b = (e == 16);
            exp_l = (e >= 16);
            checks++;
            if (button !== exp_b) begin
                errors++;
                $display("FAIL rstmid_pulse edge %0d: got %b want %b", e, button, exp_b);
            end
            checks++;
            if (level !== exp_l) begin
                errors++;
                $display("FAIL rstmid_level edge %0d: got %b want %b", e, level, exp_l);
            end
            @(negedge clk);
            if (e + 1 == 4)  rst = 1'b0;
            if (e + 1 == 10) rst = 1'b1;
        end
        settle_idle();
    endtask

    task automatic test_sequencer();
        int         pulses;
        logic [2:0] exp_colour;
        pulses = 0;
        @(negedge clk);
        seq_clr = 1'b1;
        @(negedge clk);
        seq_clr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            for (int c = 0; c < 22; c++) begin
                @(negedge clk);
                btn_raw = (c < 10);
                @(posedge clk); #1;
                if (button === 1'b1) pulses++;
            end
            exp_colour = 3'(((k - 1) % 6) + 1);
            checks++;
            if (colour !== exp_colour) begin
                errors++;
                $display("FAIL seq_colour press %0d: got %0d want %0d", k, colour, exp_colour);
            end
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL seq_pulses: got %0d want 10", pulses);
        end
        settle_idle();
    endtask

    task automatic test_repeat();
        logic exp_b, exp_l;
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 0; e <= 31; e++) begin
            @(posedge clk); #1;
`ifdef BUTTON_REPEAT_EN
            exp_b = (e == 6) || (e == 14) || (e == 18) || (e == 22) || (e == 26) || (e == 30);
`else
            exp_b = (e == 6);
`endif
            exp_l = (e >= 6);
            checks++;
            if (button !== exp_b) begin
                errors++;
                $display("FAIL repeat_pulse edge %0d: got %b want %b", e, button, exp_b);
            end
            checks++;
            if (level !== exp_l) begin
                errors++;
                $display("FAIL repeat_level edge %0d: got %b want %b", e, level, exp_l);
            end
            @(negedge clk);
            btn_raw = (e + 1 <= 29);
        end
        settle_idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        btn_raw = 1'b0;
        seq_clr = 1'b1;
        test_reset();
        seq_clr = 1'b0;
        test_press();
        test_glitch();
        test_min_press();
        test_bounce_release();
        test_reset_mid_press();
        test_sequencer();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples required to accept a press or a release (legal 2..65535).
REQ-002 Parameter REPEAT_DELAY, default 8: hold cycles after an accepted press before the first auto-repeat pulse (used only with BUTTON_REPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 4: cycles between auto-repeat pulses (used only with BUTTON_REPEAT_EN).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
REQ-006 btn_raw  input  1  raw, asynchronous, bouncing push-button level.
REQ-007 button  output  1  registered one-cycle press pulse; drives the LED colour-sequencer button input downstream.
REQ-008 level  output  1  registered debounced button level.

Function
REQ-009 btn_raw SHALL pass through a 2-flop synchroniser; no other logic SHALL sample btn_raw.
REQ-010 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-011 IDLE: synced=1 -> PRESS_WAIT, count=1; otherwise stay.
REQ-012 PRESS_WAIT: synced=1 -> count+1; count reaching DEBOUNCE_CYCLES -> PRESSED; synced=0 -> IDLE, count=0.
REQ-013 PRESSED: synced=0 -> RELEASE_WAIT, count=1; otherwise stay.
REQ-014 RELEASE_WAIT: synced=0 -> count+1; count reaching DEBOUNCE_CYCLES -> IDLE; synced=1 -> PRESSED, count=0, no new pulse.
REQ-015 button SHALL be 1 for exactly one cycle, on the cycle the FSM enters PRESSED from PRESS_WAIT: rising edge DEBOUNCE_CYCLES+2 after btn_raw is first sampled high and held.
REQ-016 level SHALL be 1 in PRESSED and RELEASE_WAIT, else 0; it rises on the same edge as the press pulse.
REQ-017 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1) bits; it SHALL saturate and never wrap.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no pulse and no level change.
REQ-019 No two press pulses SHALL occur without an intervening accepted release, except auto-repeat pulses under REQ-023.

Reset
REQ-020 While rst=0: state=IDLE, count=0, synchroniser flops=0, button=0, level=0, repeat counter=0.
REQ-021 Reset asserted mid-press SHALL abort the press; after deassertion a held button SHALL debounce afresh and give one pulse at edge DEBOUNCE_CYCLES+2 after release of reset.

Configuration
REQ-022 Macro BUTTON_REPEAT_EN SHALL select the auto-repeat feature.
REQ-023 Defined: in PRESSED, the first extra pulse SHALL occur REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles while in PRESSED; leaving PRESSED resets the repeat counter; RELEASE_WAIT bounce back to PRESSED restarts REPEAT_DELAY.
REQ-024 Undefined: no repeat logic SHALL be synthesised; REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored; exactly one pulse per accepted press.

Structure
REQ-025 Package button_pkg SHALL hold the FSM state typedef (2-bit enum) and the default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-026 The synchroniser SHALL be a separate sub-module, sync_2ff (clk, rst, d, q), with the same asynchronous active-low reset.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-027 btn_raw 0->1 sampled at edge 0, held 20 cycles -> button=1 only in the cycle after edge 6; level=1 from edge 6.
REQ-028 btn_raw high for 3 cycles, then low -> button stays 0 and level stays 0 throughout.
REQ-029 Press accepted, then btn_raw low 2 cycles, high 2, low 10 -> no second pulse; level falls 4 synced cycles after the final fall.
REQ-030 rst=0 at edge 4 of a held press, released at edge 10 -> no pulse before edge 10; a single pulse at edge 16.
REQ-031 Ten accepted press/release cycles, with the downstream colour sequencer attached -> exactly ten pulses, and the colour advances 1..6 then wraps to 1.
REQ-032 BUTTON_REPEAT_EN defined, held 30 cycles -> pulses at edges 6, 14, 18, 22, 26, 30; undefined -> pulse at edge 6 only.
